// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and small elaboration-time helpers.
package vga_timing_pkg;

  // Ceiling log2, used to size counters from a total count.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;
  localparam bit          VGA640_H_POL    = 1'b0;
  localparam bit          VGA640_V_POL    = 1'b0;
  localparam int unsigned VGA640_H_TOTAL  = VGA640_H_ACTIVE + VGA640_H_FP + VGA640_H_SYNC + VGA640_H_BP;
  localparam int unsigned VGA640_V_TOTAL  = VGA640_V_ACTIVE + VGA640_V_FP + VGA640_V_SYNC + VGA640_V_BP;
  localparam int unsigned VGA640_CNT_W    = clog2(max_u(VGA640_H_TOTAL, VGA640_V_TOTAL));

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FP     = 40;
  localparam int unsigned SVGA800_H_SYNC   = 128;
  localparam int unsigned SVGA800_H_BP     = 88;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FP     = 1;
  localparam int unsigned SVGA800_V_SYNC   = 4;
  localparam int unsigned SVGA800_V_BP     = 23;
  localparam bit          SVGA800_H_POL    = 1'b1;
  localparam bit          SVGA800_V_POL    = 1'b1;
  localparam int unsigned SVGA800_H_TOTAL  = SVGA800_H_ACTIVE + SVGA800_H_FP + SVGA800_H_SYNC + SVGA800_H_BP;
  localparam int unsigned SVGA800_V_TOTAL  = SVGA800_V_ACTIVE + SVGA800_V_FP + SVGA800_V_SYNC + SVGA800_V_BP;
  localparam int unsigned SVGA800_CNT_W    = clog2(max_u(SVGA800_H_TOTAL, SVGA800_V_TOTAL));

endpackage

// File: rtl/pixel_clk_en.sv
// Divides the system clock down to a one-cycle pixel strobe; en stalls the divider.
module pixel_clk_en
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic reloj,
  input  logic resetM,
  input  logic en,
  output logic pixel_tick_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // Strobe decoded from the divider register, gated by the live enable.
  assign pixel_tick_c = en && (div == DIV_LAST);

  // Divider advances only while enabled, so a stall resumes without losing a pixel.
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, coordinates, syncs, blanking and markers.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int unsigned H_FP       = VGA640_H_FP,
  parameter int unsigned H_SYNC     = VGA640_H_SYNC,
  parameter int unsigned H_BP       = VGA640_H_BP,
  parameter int unsigned V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int unsigned V_FP       = VGA640_V_FP,
  parameter int unsigned V_SYNC     = VGA640_V_SYNC,
  parameter int unsigned V_BP       = VGA640_V_BP,
  parameter bit          H_SYNC_POL = VGA640_H_POL,
  parameter bit          V_SYNC_POL = VGA640_V_POL,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CNT_W      = VGA640_CNT_W
) (
  input  logic             reloj,
  input  logic             resetM,
  input  logic             en,
  output logic             pixel_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             h_sync,
  output logic             v_sync,
  output logic             video_on,
  output logic             v_blank,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST_C     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACTIVE_C   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACTIVE_C   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START_C   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Reject timing sets the counters cannot represent.
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CLK_DIV < 1 || (64'(1) << CNT_W) < 64'(max_u(H_TOTAL, V_TOTAL))) begin : g_bad_cfg
    $error("vga_timing_gen: invalid timing parameters");
  end

  pixel_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clk_en (
    .reloj        (reloj),
    .resetM       (resetM),
    .en           (en),
    .pixel_tick_c (pixel_tick)
  );

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_sync_nxt;
  logic             v_sync_nxt;
  logic             video_on_nxt;
  logic             v_blank_nxt;
  logic             line_start_nxt;
  logic             frame_start_nxt;

  // Next raster position and its decode, so coordinates and syncs load together.
  always_comb begin
    h_nxt = pixel_x + CNT_W'(1);
    v_nxt = pixel_y;
    if (pixel_x == H_LAST_C) begin
      h_nxt = '0;
      v_nxt = (pixel_y == V_LAST_C) ? '0 : pixel_y + CNT_W'(1);
    end
    h_sync_nxt      = (h_nxt >= HS_START_C && h_nxt < HS_END_C) ? H_SYNC_POL : ~H_SYNC_POL;
    v_sync_nxt      = (v_nxt >= VS_START_C && v_nxt < VS_END_C) ? V_SYNC_POL : ~V_SYNC_POL;
    video_on_nxt    = (h_nxt < H_ACTIVE_C) && (v_nxt < V_ACTIVE_C);
    v_blank_nxt     = (v_nxt >= V_ACTIVE_C);
    line_start_nxt  = (h_nxt == '0);
    frame_start_nxt = (h_nxt == '0) && (v_nxt == '0);
  end

  // Raster registers; reset parks at the last pixel so the first tick lands on (0,0).
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      pixel_x     <= H_LAST_C;
      pixel_y     <= V_LAST_C;
      h_sync      <= ~H_SYNC_POL;
      v_sync      <= ~V_SYNC_POL;
      video_on    <= 1'b0;
      v_blank     <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pixel_tick) begin
      pixel_x     <= h_nxt;
      pixel_y     <= v_nxt;
      h_sync      <= h_sync_nxt;
      v_sync      <= v_sync_nxt;
      video_on    <= video_on_nxt;
      v_blank     <= v_blank_nxt;
      line_start  <= line_start_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default, tiny and positive-polarity instances.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       tick;
    logic       hs;
    logic       vs;
    logic       von;
    logic       vb;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, div_n;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int   idx;
    obs_t o;
  } exp_t;

  logic reloj = 1'b0;
  logic resetM;
  logic en;

  always #5 reloj = ~reloj;

  logic       tk0, hs0, vs0, vo0, vb0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       tk1, hs1, vs1, vo1, vb1, ls1, fs1;
  logic [9:0] x1, y1;
  logic       tk2, hs2, vs2, vo2, vb2, ls2, fs2;
  logic [9:0] x2, y2;
  obs_t       obs0, obs1, obs2;

  assign obs0 = {x0, y0, tk0, hs0, vs0, vo0, vb0, ls0, fs0};
  assign obs1 = {x1, y1, tk1, hs1, vs1, vo1, vb1, ls1, fs1};
  assign obs2 = {x2, y2, tk2, hs2, vs2, vo2, vb2, ls2, fs2};

  vga_timing_gen u_dut (
    .reloj(reloj), .resetM(resetM), .en(en), .pixel_tick(tk0),
    .pixel_x(x0), .pixel_y(y0), .h_sync(hs0), .v_sync(vs0),
    .video_on(vo0), .v_blank(vb0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)
  ) u_small (
    .reloj(reloj), .resetM(resetM), .en(en), .pixel_tick(tk1),
    .pixel_x(x1), .pixel_y(y1), .h_sync(hs1), .v_sync(vs1),
    .video_on(vo1), .v_blank(vb1), .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(1)
  ) u_pol (
    .reloj(reloj), .resetM(resetM), .en(en), .pixel_tick(tk2),
    .pixel_x(x2), .pixel_y(y2), .h_sync(hs2), .v_sync(vs2),
    .video_on(vo2), .v_blank(vb2), .line_start(ls2), .frame_start(fs2)
  );

  cfg_t cfg  [3];
  int   m_div[3];
  int   m_h  [3];
  int   m_v  [3];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t get_obs(input int i);
    case (i)
      0:       return obs0;
      1:       return obs1;
      default: return obs2;
    endcase
  endfunction

  function automatic int h_tot(input int i);
    return cfg[i].ha + cfg[i].hfp + cfg[i].hsw + cfg[i].hbp;
  endfunction

  function automatic int v_tot(input int i);
    return cfg[i].va + cfg[i].vfp + cfg[i].vsw + cfg[i].vbp;
  endfunction

  task automatic model_reset(input int i);
    m_div[i] = 0;
    m_h[i]   = h_tot(i) - 1;
    m_v[i]   = v_tot(i) - 1;
  endtask

  task automatic model_edge(input int i, input bit r, input bit e);
    if (r) begin
      model_reset(i);
    end else if (e) begin
      if (m_div[i] == cfg[i].div_n - 1) begin
        m_div[i] = 0;
        if (m_h[i] == h_tot(i) - 1) begin
          m_h[i] = 0;
          m_v[i] = (m_v[i] == v_tot(i) - 1) ? 0 : m_v[i] + 1;
        end else begin
          m_h[i] = m_h[i] + 1;
        end
      end else begin
        m_div[i] = m_div[i] + 1;
      end
    end
  endtask

  function automatic obs_t model_out(input int i, input bit e);
    obs_t o;
    int   hs_a, vs_a;
    hs_a   = cfg[i].ha + cfg[i].hfp;
    vs_a   = cfg[i].va + cfg[i].vfp;
    o.x    = 10'(m_h[i]);
    o.y    = 10'(m_v[i]);
    o.tick = e && (m_div[i] == cfg[i].div_n - 1);
    o.hs   = (m_h[i] >= hs_a && m_h[i] < hs_a + cfg[i].hsw) ? cfg[i].hpol : !cfg[i].hpol;
    o.vs   = (m_v[i] >= vs_a && m_v[i] < vs_a + cfg[i].vsw) ? cfg[i].vpol : !cfg[i].vpol;
    o.von  = (m_h[i] < cfg[i].ha) && (m_v[i] < cfg[i].va);
    o.vb   = (m_v[i] >= cfg[i].va);
    o.ls   = (m_h[i] == 0);
    o.fs   = (m_h[i] == 0) && (m_v[i] == 0);
    return o;
  endfunction

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
  task automatic step(input bit r, input bit e);
    exp_t t;
    @(negedge reloj);
    resetM = r;
    en     = e;
    for (int i = 0; i < 3; i++) begin
      model_edge(i, r, e);
      t.idx = i;
      t.o   = model_out(i, e);
      exp_q.push_back(t);
    end
    @(posedge reloj);
    #1;
    while (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      check($sformatf("u%0d x%0d y%0d", t.idx, t.o.x, t.o.y), 32'(get_obs(t.idx)), 32'(t.o));
    end
  endtask

  initial begin
    int   n, per, hs_low, hs_min, hs_max, von_cnt, von_max;
    int   last_fs, fs_per, vs_bad;
    obs_t snap, prev0, prev1, cur1;

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0};
    cfg[1] = '{4, 1, 1, 1, 3, 1, 1, 1, 1, 1'b0, 1'b0};
    cfg[2] = '{640, 16, 96, 48, 3, 1, 1, 1, 1, 1'b1, 1'b1};
    resetM = 1'b1;
    en     = 1'b0;
    for (int i = 0; i < 3; i++) model_reset(i);

    // Reset state before any clock edge
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("reset u%0d", i), 32'(get_obs(i)), 32'(model_out(i, 1'b0)));
    repeat (3) step(1'b1, 1'b0);

    // Release: tick in the 4th enabled cycle (3 edges after the release edge)
    n = 1;
    step(1'b0, 1'b1);
    while (!obs0.tick && n < 10) begin
      step(1'b0, 1'b1);
      n++;
    end
    check("first_tick", 32'(n), 32'd3);
    step(1'b0, 1'b1);
    check("origin", {obs0.x, obs0.y, obs0.fs, obs0.ls, obs0.von}, {10'd0, 10'd0, 3'b111});
    n = 1;
    do begin
      step(1'b0, 1'b1);
      n++;
    end while (!obs0.tick && n < 10);
    check("tick_period", 32'(n), 32'd4);

    // Stall at pixel_x=100 with the divider part-way through a pixel
    n = 0;
    while (obs0.x != 10'd100 && n < 1000) begin
      step(1'b0, 1'b1);
      n++;
    end
    check("reach_x100", 32'(obs0.x), 32'd100);
    step(1'b0, 1'b1);
    snap = obs0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0);
      check("stall_hold", 32'(obs0), 32'(snap));
    end
    n = 0;
    do begin
      step(1'b0, 1'b1);
      n++;
    end while (obs0.x != 10'd101 && n < 10);
    check("resume_cycles", 32'(n), 32'd3);

    // Measure one full default line, and the tiny frame in parallel
    n = 0;
    do begin
      prev0 = obs0;
      step(1'b0, 1'b1);
      n++;
    end while (!(obs0.ls && !prev0.ls) && n < 4000);
    check("line_align", 32'(obs0.x), 32'd0);
    per = 0; hs_low = 0; hs_min = 9999; hs_max = -1; von_cnt = 0; von_max = -1;
    last_fs = -1; fs_per = 0; vs_bad = 0;
    do begin
      prev0 = obs0;
      prev1 = obs1;
      if (!obs0.hs) begin
        hs_low++;
        if (int'(obs0.x) < hs_min) hs_min = int'(obs0.x);
        if (int'(obs0.x) > hs_max) hs_max = int'(obs0.x);
      end
      if (obs0.von) begin
        von_cnt++;
        if (int'(obs0.x) > von_max) von_max = int'(obs0.x);
      end
      if ((obs1.vs == 1'b0) != (obs1.y == 10'd4)) vs_bad++;
      step(1'b0, 1'b1);
      per++;
      cur1 = obs1;
      if (cur1.fs && !prev1.fs) begin
        if (last_fs >= 0 && fs_per == 0) fs_per = per - last_fs;
        last_fs = per;
      end
      if (cur1.y != prev1.y)
        check("small_ywrap", {prev1.x, cur1.x}, {10'd6, 10'd0});
    end while (!(obs0.ls && !prev0.ls) && per < 4000);
    check("line_period", 32'(per), 32'd3200);
    check("hs_low_cycles", 32'(hs_low), 32'd384);
    check("hs_first_x", 32'(hs_min), 32'd656);
    check("hs_last_x", 32'(hs_max), 32'd751);
    check("von_cycles", 32'(von_cnt), 32'd2560);
    check("von_last_x", 32'(von_max), 32'd639);
    check("small_frame", 32'(fs_per), 32'(h_tot(1) * v_tot(1) * cfg[1].div_n));
    check("small_vsync", 32'(vs_bad), 32'd0);

    // Asynchronous reset while the positive-polarity instance is in h_sync on its sync line
    n = 0;
    while (!(obs2.y == 10'd4 && obs2.hs) && n < 12000) begin
      step(1'b0, 1'b1);
      n++;
    end
    check("pol_in_sync", {obs2.y, obs2.hs, obs2.vs}, {10'd4, 2'b11});
    #2;
    resetM = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      model_reset(i);
      check($sformatf("async u%0d", i), 32'(get_obs(i)), 32'(model_out(i, 1'b1)));
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("pol_restart", {obs2.x, obs2.y, obs2.fs, obs2.hs, obs2.vs}, {10'd0, 10'd0, 3'b100});
    repeat (8) step(1'b0, 1'b1);
    check("dut_restart", {obs0.x, obs0.y, obs0.fs}, {10'd1, 10'd0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
